// File: rtl/pipe_pkg.sv
// Shared opcode map, FSM encoding and decode record for the 4-stage pipeline
// sequencer.
package pipe_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BPZ   = 4'b1101;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [2:0] SHIFT_LOW3 = 3'b011;
    localparam logic [2:0] ORI_LOW3   = 3'b111;

    localparam logic [7:0] NOP_WORD_DEF = 8'b00001010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic reads_r1;
        logic reads_r2;
        logic reads_k1;
        logic is_load;
        logic is_branch;
        logic is_stop;
    } dec_t;

endpackage

// File: rtl/pipe_instr_decode.sv
// Classifies one instruction word: which registers it reads and whether it
// is a load, branch or stop.
module pipe_instr_decode
    import pipe_pkg::*;
(
    input  logic [7:0] instr,
    output logic       reads_r1,
    output logic       reads_r2,
    output logic       reads_k1,
    output logic       is_load,
    output logic       is_branch,
    output logic       is_stop
);

    logic [3:0] op;
    logic       unused_fields;

    assign op            = instr[3:0];
    assign unused_fields = ^instr[7:4];

    always_comb begin
        reads_r1  = 1'b0;
        reads_r2  = 1'b0;
        reads_k1  = 1'b0;
        is_load   = 1'b0;
        is_branch = 1'b0;
        is_stop   = 1'b0;
        case (op)
            OP_LOAD: begin
                reads_r2 = 1'b1;
                is_load  = 1'b1;
            end
            OP_STORE, OP_ADD, OP_SUB, OP_NAND: begin
                reads_r1 = 1'b1;
                reads_r2 = 1'b1;
            end
            OP_BPZ, OP_BZ, OP_BNZ: is_branch = 1'b1;
            OP_STOP:               is_stop   = 1'b1;
            OP_NOP:                ;
            default: begin
                // shift and ori occupy two opcodes each, keyed on the low 3 bits
                if (op[2:0] == SHIFT_LOW3)
                    reads_r1 = 1'b1;
                else if (op[2:0] == ORI_LOW3)
                    reads_k1 = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline sequencer: per-stage load/flush/bubble and PC controls, load-use
// stall, taken-branch flush, stop/halt and saturating performance counters.
module pipe_hazard_sequencer
    import pipe_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [7:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       IR2Out,
    input  logic [7:0]       IR3Out,
    input  logic [7:0]       IR4Out,
    input  logic             Z,
    input  logic             N,
    output logic             PCWrite,
    output logic             PCSel,
    output logic             IR1Load,
    output logic             IR2Load,
    output logic             IR3Load,
    output logic             IR4Load,
    output logic             IR1Flush,
    output logic             IR2Flush,
    output logic             IR3Bubble,
    output logic             Halted,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state, nxt;
    logic [2:0][7:0] ir;
    dec_t [2:0]      dec;
    logic [1:0]      dest;
    logic            ir3_live, taken, hazard, stop4;
    logic            cyc_inc, stall_inc, flush_inc;
    logic            unused_dec;

    // ir[0]=IR2, ir[1]=IR3, ir[2]=IR4
    assign ir = {IR4Out, IR3Out, IR2Out};

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dec
            pipe_instr_decode u_dec (
                .instr     (ir[g]),
                .reads_r1  (dec[g].reads_r1),
                .reads_r2  (dec[g].reads_r2),
                .reads_k1  (dec[g].reads_k1),
                .is_load   (dec[g].is_load),
                .is_branch (dec[g].is_branch),
                .is_stop   (dec[g].is_stop)
            );
        end
    endgenerate

    assign unused_dec = ^{dec[0].is_load, dec[0].is_branch, dec[0].is_stop,
                          dec[1].reads_r1, dec[1].reads_r2, dec[1].reads_k1,
                          dec[1].is_stop,
                          dec[2].reads_r1, dec[2].reads_r2, dec[2].reads_k1,
                          dec[2].is_load, dec[2].is_branch};

    // An injected bubble in IR3 must never resolve as a branch or a load,
    // even if NOP_WORD is overridden to collide with one.
    assign ir3_live = (IR3Out != NOP_WORD);
    assign dest     = IR3Out[7:6];
    assign stop4    = dec[2].is_stop;

    assign taken = ir3_live && dec[1].is_branch &&
                   (((IR3Out[3:0] == OP_BPZ) && !N) ||
                    ((IR3Out[3:0] == OP_BZ)  &&  Z) ||
                    ((IR3Out[3:0] == OP_BNZ) && !Z));

    assign hazard = ir3_live && dec[1].is_load &&
                    ((dec[0].reads_r1 && (IR2Out[7:6] == dest)) ||
                     (dec[0].reads_r2 && (IR2Out[5:4] == dest)) ||
                     (dec[0].reads_k1 && (dest == 2'd1)));

    always_comb begin
        nxt       = state;
        PCWrite   = 1'b0;
        PCSel     = 1'b0;
        IR1Load   = 1'b0;
        IR2Load   = 1'b0;
        IR3Load   = 1'b0;
        IR4Load   = 1'b0;
        IR1Flush  = 1'b0;
        IR2Flush  = 1'b0;
        IR3Bubble = 1'b0;
        Halted    = 1'b0;
        cyc_inc   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state)
            ST_IDLE: nxt = ST_RUN;
            ST_RUN, ST_STALL: begin
                cyc_inc = 1'b1;
                if (stop4) begin
                    nxt = ST_HALT;
                end else if (taken) begin
                    {PCWrite, PCSel, IR1Load, IR2Load, IR3Load, IR4Load} = '1;
                    {IR1Flush, IR2Flush, IR3Bubble} = '1;
                    flush_inc = 1'b1;
                    nxt       = ST_RUN;
                end else if ((state == ST_RUN) && hazard) begin
                    // hold IR1/IR2 and PC; the load moves on to IR4
                    IR3Load   = 1'b1;
                    IR3Bubble = 1'b1;
                    IR4Load   = 1'b1;
                    stall_inc = 1'b1;
                    nxt       = ST_STALL;
                end else begin
                    {PCWrite, IR1Load, IR2Load, IR3Load, IR4Load} = '1;
                    nxt = ST_RUN;
                end
            end
            ST_HALT: Halted = 1'b1;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            CycleCount <= '0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state <= nxt;
            if (cyc_inc && (CycleCount != CNT_MAX))
                CycleCount <= CycleCount + CNT_ONE;
            if (stall_inc && (StallCount != CNT_MAX))
                StallCount <= StallCount + CNT_ONE;
            if (flush_inc && (FlushCount != CNT_MAX))
                FlushCount <= FlushCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Randomized bench for pipe_hazard_sequencer against a rule-level model;
// a second instance with 4-bit counters exercises saturation.
module tb_pipe_hazard_sequencer;

    localparam logic [7:0] NOP = 8'h0A;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] ir2, ir3, ir4;
    logic       z, n;

    logic        pcw_a, pcs_a, l1_a, l2_a, l3_a, l4_a, f1_a, f2_a, b3_a, h_a;
    logic [15:0] cyc_a, stl_a, fls_a;
    logic        pcw_b, pcs_b, l1_b, l2_b, l3_b, l4_b, f1_b, f2_b, b3_b, h_b;
    logic [3:0]  cyc_b, stl_b, fls_b;

    logic [9:0] ctl_a, ctl_b;
    assign ctl_a = {pcw_a, pcs_a, l1_a, l2_a, l3_a, l4_a, f1_a, f2_a, b3_a, h_a};
    assign ctl_b = {pcw_b, pcs_b, l1_b, l2_b, l3_b, l4_b, f1_b, f2_b, b3_b, h_b};

    pipe_hazard_sequencer #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .IR2Out(ir2), .IR3Out(ir3), .IR4Out(ir4),
        .Z(z), .N(n), .PCWrite(pcw_a), .PCSel(pcs_a),
        .IR1Load(l1_a), .IR2Load(l2_a), .IR3Load(l3_a), .IR4Load(l4_a),
        .IR1Flush(f1_a), .IR2Flush(f2_a), .IR3Bubble(b3_a), .Halted(h_a),
        .CycleCount(cyc_a), .StallCount(stl_a), .FlushCount(fls_a)
    );

    pipe_hazard_sequencer #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .IR2Out(ir2), .IR3Out(ir3), .IR4Out(ir4),
        .Z(z), .N(n), .PCWrite(pcw_b), .PCSel(pcs_b),
        .IR1Load(l1_b), .IR2Load(l2_b), .IR3Load(l3_b), .IR4Load(l4_b),
        .IR1Flush(f1_b), .IR2Flush(f2_b), .IR3Bubble(b3_b), .Halted(h_b),
        .CycleCount(cyc_b), .StallCount(stl_b), .FlushCount(fls_b)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // model: 0 idle, 1 run, 2 stall, 3 halt
    int mstate = 0;
    int m_cyc = 0, m_stl = 0, m_fls = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // bitmask of registers k0..k3 that a word reads
    function automatic logic [3:0] read_mask(input logic [7:0] w);
        logic [3:0] r1, r2;
        r1 = 4'b0001 << w[7:6];
        r2 = 4'b0001 << w[5:4];
        case (w[3:0])
            4'b0000:                   return r2;
            4'b0010, 4'b0100,
            4'b0110, 4'b1000:          return r1 | r2;
            4'b0011, 4'b1011:          return r1;
            4'b0111, 4'b1111:          return 4'b0010;
            default:                   return 4'b0000;
        endcase
    endfunction

    function automatic bit br_taken(input logic [7:0] w, input logic zz, input logic nn);
        return (w[3:0] == 4'b1101 && !nn) || (w[3:0] == 4'b0101 && zz) ||
               (w[3:0] == 4'b1001 && !zz);
    endfunction

    function automatic bit load_use(input logic [7:0] w3, input logic [7:0] w2);
        logic [3:0] m;
        m = read_mask(w2);
        return (w3[3:0] == 4'b0000) && m[w3[7:6]];
    endfunction

    function automatic int sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic cycle(input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] a4,
                         input logic zz, input logic nn, input logic rst);
        logic [9:0] e;
        int kind;
        ir2 = a2; ir3 = a3; ir4 = a4; z = zz; n = nn; reset = rst;
        e = '0;
        kind = 0;
        if (mstate == 3) e = 10'b0000000001;
        else if (mstate != 0) begin
            if (a4[3:0] == 4'b0001)              kind = 1;
            else if (br_taken(a3, zz, nn))       kind = 2;
            else if (mstate == 1 && load_use(a3, a2)) kind = 3;
            else                                 kind = 4;
            case (kind)
                2:       e = 10'b1111111110;
                3:       e = 10'b0000110010;
                4:       e = 10'b1011110000;
                default: e = 10'b0000000000;
            endcase
        end
        @(negedge clock);
        chk("ctl16", {22'd0, ctl_a}, {22'd0, e});
        chk("ctl4",  {22'd0, ctl_b}, {22'd0, e});
        chk("cyc16", {16'd0, cyc_a}, sat(m_cyc, 16));
        chk("stl16", {16'd0, stl_a}, sat(m_stl, 16));
        chk("fls16", {16'd0, fls_a}, sat(m_fls, 16));
        chk("cyc4",  {28'd0, cyc_b}, sat(m_cyc, 4));
        chk("stl4",  {28'd0, stl_b}, sat(m_stl, 4));
        chk("fls4",  {28'd0, fls_b}, sat(m_fls, 4));
        @(posedge clock);
        if (rst) begin
            mstate = 0; m_cyc = 0; m_stl = 0; m_fls = 0;
        end else begin
            if (mstate == 1 || mstate == 2) m_cyc++;
            if (kind == 2) m_fls++;
            if (kind == 3) m_stl++;
            case (mstate)
                0:       mstate = 1;
                3:       mstate = 3;
                default: mstate = (kind == 1) ? 3 : (kind == 3) ? 2 : 1;
            endcase
        end
        #1;
    endtask

    function automatic logic [7:0] rnd_word();
        logic [7:0] w;
        w = 8'($urandom);
        if ($urandom_range(0, 3) == 0) w[3:0] = 4'b0000;
        return w;
    endfunction

    initial begin
        logic [7:0] w4;
        logic       rst;
        ir2 = NOP; ir3 = NOP; ir4 = NOP; z = 0; n = 0; reset = 1'b1;
        @(posedge clock); #1;

        cycle(NOP, NOP, NOP, 0, 0, 1);
        cycle(NOP, NOP, NOP, 0, 0, 1);
        cycle(NOP, NOP, NOP, 0, 0, 0);
        cycle(NOP, NOP, NOP, 0, 0, 0);
        cycle(NOP, NOP, NOP, 0, 0, 0);

        cycle(8'b01_10_0100, 8'b10_00_0000, NOP, 0, 0, 0);
        cycle(8'b01_10_0100, NOP, 8'b10_00_0000, 0, 0, 0);
        cycle(NOP, 8'b01_10_0100, NOP, 0, 0, 0);

        cycle(8'b01_11_0100, 8'b10_00_0000, NOP, 0, 0, 0);
        cycle(8'b00001_111, 8'b01_00_0000, NOP, 0, 0, 0);
        cycle(8'b00001_111, NOP, 8'b01_00_0000, 0, 0, 0);
        cycle(NOP, 8'b00001_111, NOP, 0, 0, 0);

        cycle(NOP, 8'b00_00_0101, NOP, 1, 0, 0);
        cycle(NOP, 8'b00_00_0101, NOP, 0, 0, 0);
        cycle(NOP, 8'b00_00_1101, NOP, 0, 1, 0);
        cycle(NOP, 8'b00_00_1101, NOP, 0, 0, 0);
        cycle(NOP, 8'b00_00_1001, NOP, 0, 0, 0);

        cycle(NOP, 8'b00_00_1001, 8'h01, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(NOP, 8'b00_00_0101, NOP, 1, 0, 0);
        cycle(NOP, NOP, NOP, 0, 0, 1);
        cycle(NOP, NOP, NOP, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(NOP, NOP, NOP, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            w4 = 8'($urandom);
            if (w4[3:0] == 4'b0001) w4[3:0] = 4'b1010;
            if ($urandom_range(0, 99) == 0) w4 = 8'h01;
            rst = ($urandom_range(0, 199) == 0) ||
                  (mstate == 3 && $urandom_range(0, 7) == 0);
            cycle(rnd_word(), rnd_word(), w4, 1'($urandom), 1'($urandom), rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_sequencer.md
Name: pipe_hazard_sequencer

Overview:
Pipeline sequencing controller for the 4-stage 8-bit processor: IR1 fetch, IR2 RF read, IR3 ALU/branch resolve, IR4 memory/writeback.
- Generates per-stage load, flush and bubble controls plus PC write/select.
- Detects load-use hazards (1-cycle stall), taken branches (flush of younger stages) and stop (halt).
- Keeps saturating cycle, stall and flush counters. IR4-to-IR2 forwarding is handled by the RF controller; this block never forwards.

Parameters:
CNT_W, 16, width of each performance counter
NOP_WORD, 8'b00001010, instruction word injected for bubbles and flushes

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
IR2Out  in  8  instruction in RF-read stage
IR3Out  in  8  instruction in ALU stage
IR4Out  in  8  instruction in writeback stage
Z  in  1  zero flag, valid for the IR3 branch
N  in  1  negative flag, valid for the IR3 branch
PCWrite  out  1  PC register enable
PCSel  out  1  1 = PC loads branch target, 0 = PC+1
IR1Load, IR2Load, IR3Load, IR4Load  out  1 each  stage register enables
IR1Flush, IR2Flush  out  1 each  stage loads NOP_WORD instead of its input
IR3Bubble  out  1  IR3 loads NOP_WORD instead of IR2Out
Halted  out  1  high in HALT
CycleCount, StallCount, FlushCount  out  CNT_W each  saturating counters

Behaviour:
- Decode of an instruction word:
  - Opcode is [3:0]. Register fields: R1 = [7:6], R2 = [5:4].
  - load 0000 reads R2. store 0010 reads R1 and R2. add/sub/nand (0100/0110/1000) read R1 and R2.
  - shift ([2:0]=011) reads R1. ori ([2:0]=111) reads register 1.
  - bpz 1101, bz 0101, bnz 1001, nop 1010 and stop 0001 read nothing.
- Branch taken (IR3): bpz when N=0; bz when Z=1; bnz when Z=0.
- Load-use hazard: IR3 is a load AND IR2 reads register IR3Out[7:6].
- FSM states: IDLE, RUN, STALL, HALT. Reset forces IDLE and clears all counters.
- IDLE:
  - All outputs 0; this is also the reset value of every output.
  - Next state is RUN unconditionally (one idle cycle after reset).
- RUN, evaluated combinationally each cycle, in priority order:
  1. IR4 opcode = stop: all enables 0, next state HALT.
  2. Taken branch in IR3: PCWrite=1, PCSel=1, IR1Flush=1, IR2Flush=1, IR3Bubble=1, all loads=1. FlushCount++. Stay in RUN.
  3. Load-use hazard: PCWrite=0, IR1Load=0, IR2Load=0, IR3Load=1, IR3Bubble=1, IR4Load=1. StallCount++. Next state STALL.
  4. Otherwise: PCWrite=1, all loads=1, PCSel=0, no flush or bubble.
- STALL:
  - Lasts exactly 1 cycle. The load is now in IR4 and is forwarded by the RF controller.
  - Behaves as RUN rules 1, 2 and 4; the hazard check is skipped because IR3 is a bubble.
  - Next state RUN, unless rule 1 sends it to HALT.
- HALT: all enables, flush and bubble outputs 0; Halted=1; counters frozen. Leaves only on reset.
- Flush/bubble outputs qualify the corresponding load; they are meaningful only while that load is 1.
- Counters:
  - CycleCount increments every cycle in RUN or STALL.
  - All counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-operation: the next edge gives IDLE with counters cleared, regardless of state.
- Latency: control outputs are combinational from state and IR inputs (same cycle). State and counters are registered.

Decomposition:
- Shared package pipe_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_NAND, OP_BPZ, OP_BZ, OP_BNZ, OP_NOP, OP_STOP, SHIFT_LOW3, ORI_LOW3);
  - state encoding;
  - NOP_WORD default.
- One sub-module, pipe_instr_decode (instantiated for IR2, IR3, IR4), outputs: reads_r1, reads_r2, reads_k1, is_load, is_branch, is_stop.

Test Plan:
1. Reset high for 2 cycles, then low -> outputs all 0 for 1 cycle (IDLE), then RUN with all loads=1, PCWrite=1, counters 0, CycleCount=1 one cycle later.
2. IR3=8'b10_00_0000 (load k2), IR2=8'b01_10_0100 (add k1,k2) -> one cycle of PCWrite=0, IR1Load=0, IR2Load=0, IR3Bubble=1; next cycle normal; StallCount=1.
3. IR3=8'b10_00_0000, IR2=8'b01_11_0100 (add k1,k3) -> no stall, StallCount=0. Repeat with IR2=ori (8'b00001_111) and IR3 load to k1 (8'b01_00_0000) -> stall.
4. IR3=8'b00_00_0101 (bz): Z=1 -> PCSel=1, IR1Flush=IR2Flush=IR3Bubble=1, FlushCount=1. Z=0 -> no flush. bpz with N=1 -> not taken.
5. IR4=8'h01 (stop) with IR3=bnz and Z=0 -> no PCSel; Halted=1 next cycle and held for 10 cycles; counters frozen; reset returns to IDLE.
6. CNT_W=4, 20 RUN cycles -> CycleCount=15 (saturated, no wrap).
